// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C receiver/sender state encoding and address default
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h1A;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - two-flop synchronizer with rise/fall detect for one bus line
module i2c_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = i_pin;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Preset high so a released bus produces no edge when reset lifts.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q;
    assign o_rise  = sync_q & ~prev_q;
    assign o_fall  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave_receiver.sv
// rtl/i2c_slave_receiver.sv - I2C slave that ACKs and collects a fixed-length frame
module i2c_slave_receiver
    import i2c_pkg::*;
#(
    parameter int         BYTE = 3,
    parameter logic [6:0] ADDR = I2C_DEFAULT_ADDR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_sdat,
    output logic              o_sdat_oe,
    output logic [8*BYTE-1:0] o_dat,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_err
);

    localparam int            FW        = 8 * BYTE;
    localparam int            CW        = $clog2(BYTE + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTE - 1);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_ev, stop_ev, byte_ok, last_byte;

    i2c_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          byte_done_q, byte_done_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [FW-1:0] dat_q, dat_d;
    logic          sdat_oe_q, sdat_oe_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    i2c_sync_edge u_scl (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_sclk),
        .o_level(scl_level),
        .o_rise (scl_rise),
        .o_fall (scl_fall)
    );

    i2c_sync_edge u_sda (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_sdat),
        .o_level(sda_level),
        .o_rise (sda_rise),
        .o_fall (sda_fall)
    );

    assign start_ev  = sda_fall & scl_level;
    assign stop_ev   = sda_rise & scl_level;
    assign last_byte = (byte_cnt_q == LAST_BYTE);
    assign byte_ok   = (byte_cnt_q == '0) ? (frame_q[7:1] == ADDR)
                                          : (byte_cnt_q <= LAST_BYTE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_ev) begin
            state_d = ST_RECV;
        end else if (stop_ev) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_RECV: if (scl_fall && byte_done_q) state_d = byte_ok ? ST_ACK : ST_IGNORE;
                ST_ACK:  if (scl_fall) state_d = last_byte ? ST_IGNORE : ST_RECV;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        byte_done_d = byte_done_q;
        frame_d     = frame_q;
        dat_d       = dat_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        if (start_ev) begin
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            byte_done_d = 1'b0;
            busy_d      = 1'b1;
        end else if (stop_ev) begin
            byte_done_d = 1'b0;
            busy_d      = 1'b0;
            err_d       = (state_q == ST_RECV) || (state_q == ST_ACK);
        end else begin
            case (state_q)
                ST_RECV: begin
                    // The 3-bit counter rolls to 0 on the 8th bit, ready for the next byte.
                    if (scl_rise) begin
                        frame_d     = {frame_q[FW-2:0], sda_level};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                    end
                end
                ST_ACK: begin
                    if (scl_fall) begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        if (last_byte) begin
                            dat_d   = frame_q;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        sdat_oe_d = (state_d == ST_ACK);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            byte_done_q <= 1'b0;
            frame_q     <= '0;
            dat_q       <= '0;
            sdat_oe_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_done_q <= byte_done_d;
            frame_q     <= frame_d;
            dat_q       <= dat_d;
            sdat_oe_q   <= sdat_oe_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign o_sdat_oe = sdat_oe_q;
    assign o_dat     = dat_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// tb/tb_i2c_slave_receiver.sv - directed bench for i2c_slave_receiver
module tb_i2c_slave_receiver;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl   = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_bus;
    logic        oe_a, oe_b, valid_a, valid_b, busy_a, busy_b, err_a, err_b;
    logic [23:0] dat_a, dat_b;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int          n_ack_a = 0, n_valid_a = 0, n_err_a = 0;
    int          n_ack_b = 0, n_valid_b = 0, n_err_b = 0;
    logic        oe_a_prev = 1'b0, oe_b_prev = 1'b0;
    logic [23:0] log_a[$];

    int s_ack, s_valid, s_err, s_ack_b, s_valid_b, s_err_b, s_log;

    assign sda_bus = m_sda & ~oe_a & ~oe_b;

    always #5 clk = ~clk;

    i2c_slave_receiver #(.BYTE(3), .ADDR(7'h44)) dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_sclk(scl), .i_sdat(sda_bus),
        .o_sdat_oe(oe_a), .o_dat(dat_a), .o_valid(valid_a), .o_busy(busy_a), .o_err(err_a)
    );

    i2c_slave_receiver #(.BYTE(3), .ADDR(7'h1A)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_sclk(scl), .i_sdat(sda_bus),
        .o_sdat_oe(oe_b), .o_dat(dat_b), .o_valid(valid_b), .o_busy(busy_b), .o_err(err_b)
    );

    always @(negedge clk) begin
        oe_a_prev <= oe_a;
        oe_b_prev <= oe_b;
        if (oe_a && !oe_a_prev) n_ack_a <= n_ack_a + 1;
        if (oe_b && !oe_b_prev) n_ack_b <= n_ack_b + 1;
        if (valid_a) begin
            n_valid_a <= n_valid_a + 1;
            log_a.push_back(dat_a);
        end
        if (valid_b) n_valid_b <= n_valid_b + 1;
        if (err_a) n_err_a <= n_err_a + 1;
        if (err_b) n_err_b <= n_err_b + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cond();
        m_sda = 1'b1; scl = 1'b1; wait_clk(8);
        m_sda = 1'b0; wait_clk(8);
        scl = 1'b0; wait_clk(4);
    endtask

    task automatic rep_start();
        m_sda = 1'b1; wait_clk(4);
        scl = 1'b1; wait_clk(8);
        m_sda = 1'b0; wait_clk(8);
        scl = 1'b0; wait_clk(4);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; wait_clk(4);
        scl = 1'b1; wait_clk(8);
        scl = 1'b0; wait_clk(4);
    endtask

    task automatic ack_clock();
        m_sda = 1'b1; wait_clk(4);
        scl = 1'b1; wait_clk(8);
        scl = 1'b0; wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_clock();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wait_clk(4);
        scl = 1'b1; wait_clk(8);
        m_sda = 1'b1; wait_clk(8);
    endtask

    task automatic snap();
        s_ack = n_ack_a; s_valid = n_valid_a; s_err = n_err_a;
        s_ack_b = n_ack_b; s_valid_b = n_valid_b; s_err_b = n_err_b;
        s_log = log_a.size();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wait_clk(4);
        check("rst_oe",    {31'd0, oe_a},    32'd0);
        check("rst_dat",   {8'd0, dat_a},    32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_err",   {31'd0, err_a},   32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Frame addressed to dut_a only.
        snap();
        start_cond();
        check("f1_busy_a", {31'd0, busy_a}, 32'd1);
        send_byte(8'h89); send_byte(8'h0a); send_byte(8'hbc);
        stop_cond(); wait_clk(8);
        check("f1_acks_a",  n_ack_a - s_ack,     32'd3);
        check("f1_valid_a", n_valid_a - s_valid, 32'd1);
        check("f1_err_a",   n_err_a - s_err,     32'd0);
        check("f1_log_a",   {8'd0, log_a[log_a.size() - 1]}, 32'h890abc);
        check("f1_hold_a",  {8'd0, dat_a},       32'h890abc);
        check("f1_busy_end", {31'd0, busy_a},    32'd0);
        check("f1_acks_b",  n_ack_b - s_ack_b,     32'd0);
        check("f1_valid_b", n_valid_b - s_valid_b, 32'd0);
        check("f1_err_b",   n_err_b - s_err_b,     32'd0);
        check("f1_dat_b",   {8'd0, dat_b},         32'd0);

        // Short frame: STOP after two bytes.
        snap();
        start_cond();
        send_byte(8'h88); send_byte(8'h0a);
        m_sda = 1'b0; wait_clk(4);
        scl = 1'b1; wait_clk(8);
        m_sda = 1'b1; wait_clk(2);
        check("sf_busy_2", {31'd0, busy_a}, 32'd1);
        check("sf_err_2",  {31'd0, err_a},  32'd0);
        wait_clk(1);
        check("sf_busy_3", {31'd0, busy_a}, 32'd0);
        check("sf_err_3",  {31'd0, err_a},  32'd1);
        wait_clk(1);
        check("sf_err_4",  {31'd0, err_a},  32'd0);
        wait_clk(8);
        check("sf_err_cnt",   n_err_a - s_err,     32'd1);
        check("sf_valid_cnt", n_valid_a - s_valid, 32'd0);
        check("sf_dat_hold",  {8'd0, dat_a},       32'h890abc);

        // Repeated START discards the partial frame.
        snap();
        start_cond();
        send_byte(8'h88);
        rep_start();
        send_byte(8'h88); send_byte(8'h12); send_byte(8'h34);
        stop_cond(); wait_clk(8);
        check("rs_valid_cnt", n_valid_a - s_valid, 32'd1);
        check("rs_err_cnt",   n_err_a - s_err,     32'd0);
        check("rs_dat",       {8'd0, dat_a},       32'h881234);

        // Reset during the ACK of byte 1.
        snap();
        start_cond();
        send_byte(8'h88);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h12 >> i));
        m_sda = 1'b1; wait_clk(4);
        check("ra_oe_before", {31'd0, oe_a}, 32'd1);
        scl = 1'b1; wait_clk(4);
        rst_n = 1'b0;
        #1;
        check("ra_oe",    {31'd0, oe_a},    32'd0);
        check("ra_dat",   {8'd0, dat_a},    32'd0);
        check("ra_busy",  {31'd0, busy_a},  32'd0);
        check("ra_valid", {31'd0, valid_a}, 32'd0);
        check("ra_err",   {31'd0, err_a},   32'd0);
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        scl = 1'b0; wait_clk(8);
        stop_cond(); wait_clk(8);
        check("ra_no_err", n_err_a - s_err, 32'd0);
        start_cond();
        send_byte(8'h89); send_byte(8'h0a); send_byte(8'hbc);
        stop_cond(); wait_clk(8);
        check("ra_valid_cnt", n_valid_a - s_valid, 32'd1);
        check("ra_next_dat",  {8'd0, dat_a},       32'h890abc);

        // Two back-to-back frames.
        snap();
        for (int f = 0; f < 2; f++) begin
            start_cond();
            send_byte(8'h89); send_byte(8'h0a); send_byte(8'hbc);
            stop_cond();
        end
        wait_clk(8);
        check("bb_valid_cnt", n_valid_a - s_valid, 32'd2);
        check("bb_acks",      n_ack_a - s_ack,     32'd6);
        check("bb_err_cnt",   n_err_a - s_err,     32'd0);
        check("bb_dat0",      {8'd0, log_a[s_log]},     32'h890abc);
        check("bb_dat1",      {8'd0, log_a[s_log + 1]}, 32'h890abc);
        check("end_valid_b",  n_valid_b, 32'd0);
        check("end_err_b",    n_err_b,   32'd0);
        check("end_dat_b",    {8'd0, dat_b}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
